// File: rtl/play_scroll_ctrl_if.sv
// Song source handshake: note vector with valid/last qualifiers and a consume strobe.
interface play_scroll_ctrl_if;
  logic [7:0] song_note;
  logic       song_valid;
  logic       song_last;
  logic       song_ready;

  modport master (output song_note, output song_valid, output song_last, input song_ready);
  modport slave  (input song_note, input song_valid, input song_last, output song_ready);
endinterface

// File: rtl/play_scroll_ctrl.sv
// Play-mode scroll sequencer: tick pacing, note prefetch, start/pause/abort/drain, hit scoring.
// Optional underrun counter output enabled by defining PLAY_UNDERRUN_CNT_EN.
module play_scroll_ctrl #(
  parameter int unsigned PERIOD      = 100000,
  parameter int unsigned DRAIN_TICKS = 32,
  parameter int unsigned SCORE_W     = 10
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  play_scroll_ctrl_if.slave  song,
  input  logic [6:0]         key,
  input  logic [6:0]         bottom,
  output logic [7:0]         note,
  output logic               output_ready,
  output logic               scroll_tick,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score
`ifdef PLAY_UNDERRUN_CNT_EN
  ,
  output logic [7:0]         underrun_cnt
`endif
);

  localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned DW = (DRAIN_TICKS > 2) ? $clog2(DRAIN_TICKS) : 1;
  // Widened so a full 7-lane hit can never wrap before the clamp on narrow scores.
  localparam int unsigned AW = (SCORE_W + 1 < 4) ? 4 : SCORE_W + 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_PRE    = CW'(PERIOD - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TICKS - 1);
  localparam logic [AW-1:0] SCORE_MAX  = AW'((1 << SCORE_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] drain_cnt;
  logic          last_pending;
  logic          counting;
  logic [AW-1:0] hits;
  logic [AW-1:0] sum;
  logic [SCORE_W-1:0] score_next;

  assign counting        = (state == RUN) || (state == DRAIN);
  assign busy            = (state != IDLE);
  assign scroll_tick     = counting && (cnt == CNT_LAST) && !abort;
  assign song.song_ready = (state == RUN) && (cnt == CNT_PRE) && song.song_valid && !abort;

  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      hits = hits + AW'(key[i] & bottom[i]);
    end
    sum        = AW'(score) + hits;
    score_next = (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      drain_cnt    <= '0;
      last_pending <= 1'b0;
      note         <= '0;
      output_ready <= 1'b0;
      done         <= 1'b0;
      score        <= '0;
`ifdef PLAY_UNDERRUN_CNT_EN
      underrun_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        cnt          <= '0;
        drain_cnt    <= '0;
        last_pending <= 1'b0;
        note         <= '0;
        output_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= RUN;
              cnt          <= '0;
              drain_cnt    <= '0;
              last_pending <= 1'b0;
              score        <= '0;
`ifdef PLAY_UNDERRUN_CNT_EN
              underrun_cnt <= '0;
`endif
            end
          end
          RUN: begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (cnt == CNT_PRE) begin
              if (song.song_valid) begin
                note         <= song.song_note;
                output_ready <= 1'b1;
                if (song.song_last) last_pending <= 1'b1;
              end else begin
                note         <= '0;
                output_ready <= 1'b0;
`ifdef PLAY_UNDERRUN_CNT_EN
                if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
`endif
              end
            end
            if (cnt == CNT_LAST) score <= score_next;
            // The last note's tick hands over to DRAIN even if pause rises the same cycle.
            if ((cnt == CNT_LAST) && last_pending) begin
              state        <= DRAIN;
              last_pending <= 1'b0;
              drain_cnt    <= '0;
            end else if (pause) begin
              state <= PAUSE;
            end
          end
          PAUSE: begin
            if (!pause) state <= RUN;
          end
          DRAIN: begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (cnt == CNT_PRE) begin
              note         <= '0;
              output_ready <= 1'b0;
            end
            if (cnt == CNT_LAST) begin
              score <= score_next;
              if (drain_cnt == DRAIN_LAST) begin
                state <= IDLE;
                done  <= 1'b1;
                cnt   <= '0;
              end else begin
                drain_cnt <= drain_cnt + DW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_play_scroll_ctrl.sv
// Directed bench for play_scroll_ctrl: cycle table for a full song plus pause/abort/reset sequences.
module tb_play_scroll_ctrl;
  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic       start, pause, abort;
  logic [6:0] key, bottom;
  logic [7:0] note;
  logic       output_ready, scroll_tick, busy, done;
  logic [1:0] score;
`ifdef PLAY_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  play_scroll_ctrl_if song_bus();

  always #5 vga_clk = ~vga_clk;

  play_scroll_ctrl #(.PERIOD(4), .DRAIN_TICKS(4), .SCORE_W(2)) dut (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .song         (song_bus),
    .key          (key),
    .bottom       (bottom),
    .note         (note),
    .output_ready (output_ready),
    .scroll_tick  (scroll_tick),
    .busy         (busy),
    .done         (done),
    .score        (score)
`ifdef PLAY_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  typedef struct {
    logic       st, pa, ab, vl, ls;
    logic [7:0] sn;
    logic [6:0] ky, bt;
    logic       rdy, tk;
    logic [7:0] nt;
    logic       ordy, bsy, dn;
    logic [1:0] sc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, pa, ab, vl, ls, input logic [7:0] sn,
                     input logic [6:0] ky, bt, input logic rdy, tk, input logic [7:0] nt,
                     input logic ordy, bsy, dn, input logic [1:0] sc);
    vec_t v;
    v.st = st; v.pa = pa; v.ab = ab; v.vl = vl; v.ls = ls; v.sn = sn; v.ky = ky; v.bt = bt;
    v.rdy = rdy; v.tk = tk; v.nt = nt; v.ordy = ordy; v.bsy = bsy; v.dn = dn; v.sc = sc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic st, pa, ab, vl, ls, input logic [7:0] sn,
                       input logic [6:0] ky, bt);
    @(negedge vga_clk);
    start = st; pause = pa; abort = ab;
    song_bus.song_valid = vl; song_bus.song_last = ls; song_bus.song_note = sn;
    key = ky; bottom = bt;
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    drive(v.st, v.pa, v.ab, v.vl, v.ls, v.sn, v.ky, v.bt);
    tag = $sformatf("c%0d", idx);
    chk({tag, ".song_ready"},   32'(song_bus.song_ready), 32'(v.rdy));
    chk({tag, ".scroll_tick"},  32'(scroll_tick),         32'(v.tk));
    chk({tag, ".note"},         32'(note),                32'(v.nt));
    chk({tag, ".output_ready"}, 32'(output_ready),        32'(v.ordy));
    chk({tag, ".busy"},         32'(busy),                32'(v.bsy));
    chk({tag, ".done"},         32'(done),                32'(v.dn));
    chk({tag, ".score"},        32'(score),               32'(v.sc));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    song_bus.song_valid = 1'b0; song_bus.song_last = 1'b0; song_bus.song_note = '0;
    key = '0; bottom = '0;

    // Song: 0x01, 0x02, gap, 0x44(last); hits +2, +1 (clamp), +7 (clamp); then 4 drain ticks.
    add(1,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,0,0,0);  // IDLE, start
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,1,0,0);  // cnt0
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,1,0,0);  // cnt1
    add(0,0,0,1,0,8'h01,7'h00,7'h00, 1,0,8'h00,0,1,0,0);  // cnt2 prefetch 01
    add(0,0,0,0,0,8'h00,7'h05,7'h07, 0,1,8'h01,1,1,0,0);  // tick, hit 2
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h01,1,1,0,2);
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h01,1,1,0,2);
    add(0,0,0,1,0,8'h02,7'h00,7'h00, 1,0,8'h01,1,1,0,2);  // prefetch 02
    add(0,0,0,0,0,8'h00,7'h7F,7'h01, 0,1,8'h02,1,1,0,2);  // tick, hit 1 -> 3
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h02,1,1,0,3);
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h02,1,1,0,3);
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h02,1,1,0,3);  // prefetch gap
    add(0,0,0,0,0,8'h00,7'h7F,7'h7F, 0,1,8'h00,0,1,0,3);  // gap tick, hit 7 saturates
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,1,0,3);
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,1,0,3);
    add(0,0,0,1,1,8'h44,7'h00,7'h00, 1,0,8'h00,0,1,0,3);  // prefetch 44 last
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,1,8'h44,1,1,0,3);  // tick -> DRAIN
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h44,1,1,0,3);  // DRAIN cnt0
    add(0,1,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h44,1,1,0,3);  // pause ignored
    add(0,1,0,1,0,8'h55,7'h00,7'h00, 0,0,8'h44,1,1,0,3);  // drain prefetch, no ready
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,1,8'h00,0,1,0,3);  // drain tick 1
    for (int k = 0; k < 3; k++) begin
      add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,1,0,3);
      add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,1,0,3);
      add(0,0,0,1,0,8'h66,7'h00,7'h00, 0,0,8'h00,0,1,0,3);
      add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,1,8'h00,0,1,0,3);  // drain ticks 2..4
    end
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,0,1,3);  // done, busy low
    add(0,0,0,0,0,8'h00,7'h00,7'h00, 0,0,8'h00,0,0,0,3);

    // Reset state
    repeat (2) @(negedge vga_clk);
    #1;
    chk("rst.note", 32'(note), 32'h0);
    chk("rst.output_ready", 32'(output_ready), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.score", 32'(score), 32'h0);
    chk("rst.scroll_tick", 32'(scroll_tick), 32'h0);
    @(negedge vga_clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(i, tbl[i]);
`ifdef PLAY_UNDERRUN_CNT_EN
    chk("underrun_after_song", 32'(underrun_cnt), 32'd1);
`endif

    // Pause for 10 cycles at count 1; tick follows 2 cycles after release.
    drive(1,0,0,0,0,8'h00,7'h00,7'h00);
    drive(0,0,0,1,0,8'h11,7'h00,7'h00);
    chk("pause.score_cleared", 32'(score), 32'h0);
`ifdef PLAY_UNDERRUN_CNT_EN
    chk("pause.underrun_cleared", 32'(underrun_cnt), 32'd0);
`endif
    drive(0,1,0,1,0,8'h11,7'h00,7'h00);
    chk("pause.enter_tick", 32'(scroll_tick), 32'h0);
    for (int k = 0; k < 9; k++) begin
      drive(0,1,0,1,0,8'h11,7'h00,7'h00);
      chk($sformatf("pause.held%0d.tick", k), 32'(scroll_tick), 32'h0);
      chk($sformatf("pause.held%0d.ready", k), 32'(song_bus.song_ready), 32'h0);
    end
    drive(0,0,0,1,0,8'h11,7'h00,7'h00);
    chk("pause.release.tick", 32'(scroll_tick), 32'h0);
    drive(0,0,0,1,0,8'h11,7'h00,7'h00);
    chk("pause.resume.ready", 32'(song_bus.song_ready), 32'h1);
    chk("pause.resume.tick", 32'(scroll_tick), 32'h0);
    drive(0,0,0,0,0,8'h00,7'h05,7'h07);
    chk("pause.resume.tick2", 32'(scroll_tick), 32'h1);
    chk("pause.resume.note", 32'(note), 32'h11);

    // Abort together with pause in RUN; score survives.
    drive(0,0,0,0,0,8'h00,7'h00,7'h00);
    chk("abort.pre_score", 32'(score), 32'h2);
    drive(0,1,1,0,0,8'h00,7'h00,7'h00);
    drive(0,0,0,0,0,8'h00,7'h00,7'h00);
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.note", 32'(note), 32'h0);
    chk("abort.output_ready", 32'(output_ready), 32'h0);
    chk("abort.score_kept", 32'(score), 32'h2);
    for (int k = 0; k < 8; k++) begin
      drive(0,0,0,1,0,8'h22,7'h00,7'h00);
      chk($sformatf("abort.idle%0d.tick", k), 32'(scroll_tick), 32'h0);
      chk($sformatf("abort.idle%0d.ready", k), 32'(song_bus.song_ready), 32'h0);
    end

    // Async reset in the middle of DRAIN.
    drive(1,0,0,0,0,8'h00,7'h00,7'h00);
    drive(0,0,0,0,0,8'h00,7'h00,7'h00);
    drive(0,0,0,0,0,8'h00,7'h00,7'h00);
    drive(0,0,0,1,1,8'h44,7'h00,7'h00);
    chk("drain.last_ready", 32'(song_bus.song_ready), 32'h1);
    drive(0,0,0,0,0,8'h00,7'h05,7'h07);
    chk("drain.last_tick", 32'(scroll_tick), 32'h1);
    drive(0,0,0,0,0,8'h00,7'h00,7'h00);
    chk("drain.busy", 32'(busy), 32'h1);
    chk("drain.note", 32'(note), 32'h44);
    chk("drain.score", 32'(score), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.note", 32'(note), 32'h0);
    chk("arst.output_ready", 32'(output_ready), 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.score", 32'(score), 32'h0);
    chk("arst.done", 32'(done), 32'h0);
    @(negedge vga_clk);
    rst_n = 1'b1;
    drive(0,0,0,1,0,8'h33,7'h00,7'h00);
    chk("arst.after.busy", 32'(busy), 32'h0);
    chk("arst.after.ready", 32'(song_bus.song_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/play_scroll_ctrl.md
Name: play_scroll_ctrl

Overview:
Sequencer for the play-mode falling-note display. Paces the scroll with a programmable tick and fetches one 8-bit note vector per tick from the song source over a valid/ready handshake. Presents `note`/`output_ready` to the note-block display, handles start/pause/abort/drain, and judges player hits against the display's bottom row. Sits between the song ROM reader and the play-mode VGA note renderer.

Parameters:
- PERIOD, 100000: `vga_clk` cycles per scroll tick; must be ≥ 2.
- DRAIN_TICKS, 32: ticks of empty rows shifted after the last note so the screen clears (display column depth).
- SCORE_W, 10: width of the hit score counter.

Ports:
- `vga_clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a song from IDLE.
- `pause`  in  1  level; freezes scrolling while high.
- `abort`  in  1  one-cycle pulse; returns to IDLE from any state.
- `song_note`  in  8  note vector from the song source (bit0=C … bit6=B, bit7 unused).
- `song_valid`  in  1  `song_note` is valid.
- `song_last`  in  1  qualifies `song_note` as the final note of the song.
- `song_ready`  out  1  one-cycle consume strobe.
- `key`  in  7  player key levels (bit0=C … bit6=B).
- `bottom`  in  7  display bottom-row lane bits.
- `note`  out  8  note vector to the display.
- `output_ready`  out  1  `note` is a real note, not a gap.
- `scroll_tick`  out  1  one-cycle shift strobe to the display.
- `busy`  out  1  high in RUN, PAUSE or DRAIN.
- `done`  out  1  one-cycle pulse when the drain completes.
- `score`  out  SCORE_W  saturating hit count.

Behaviour:
- **Reset:**
  - state=IDLE, tick counter=0, all outputs 0.
  - Reset mid-song discards everything immediately.
- **Tick counter:**
  - Runs only in RUN and DRAIN; counts 0..PERIOD-1 and wraps.
  - Cleared to 0 on every entry to RUN from IDLE.
  - Held, not cleared, in PAUSE.
  - `scroll_tick`=1 exactly in the cycle the count equals PERIOD-1.
- **Prefetch (RUN only), in the cycle the count equals PERIOD-2:**
  - If `song_valid`=1: `song_ready`=1 that cycle (combinational strobe gated by state and count). Register `note`←`song_note` and `output_ready`←1.
  - If `song_valid`=0: `note`←0 and `output_ready`←0 (gap row). `song_ready` stays 0.
  - `note`/`output_ready` are therefore stable during the following `scroll_tick` and hold until the next prefetch.
- **FSM:**
  - IDLE: `start` → RUN; `score` cleared.
  - RUN:
    - `pause`=1 → PAUSE.
    - If a consumed note had `song_last`=1 → DRAIN after that note's `scroll_tick`.
  - PAUSE: `pause`=0 → RUN; the counter resumes from its held value. No ticks, no `song_ready`.
  - DRAIN:
    - `note`=0 and `output_ready`=0 from the first drain prefetch onward.
    - Counts DRAIN_TICKS ticks, then `done`=1 for one cycle and → IDLE.
    - `pause` is ignored in DRAIN.
  - Any state: `abort` → IDLE next cycle. Counter, `note` and `output_ready` are cleared; `score` is kept.
- **Simultaneous events:**
  - `abort` beats `start` and `pause`.
  - `pause` asserted in the prefetch cycle: the prefetch still completes, then PAUSE is entered.
  - `start` outside IDLE is ignored.
- **Hit judge:**
  - In each `scroll_tick` cycle (RUN or DRAIN): `score` += popcount(`key` & `bottom`), uses values before the shift.
  - Add at SCORE_W+1 bits; clamp to 2^SCORE_W−1.
- `busy` is combinational from state.

Optional Feature:
PLAY_UNDERRUN_CNT_EN:
- Defined: adds output `underrun_cnt` (8 bits). It increments, saturating at 255, on each RUN prefetch with `song_valid`=0, and clears on `start`.
- Undefined: the port and its logic are absent; gap behaviour is unchanged.

Test Plan:
1. PERIOD=4, `song_valid`=1 with notes 0x01, 0x02, 0x44: `song_ready` pulses at counts 2, 6, 10 after `start`; `note` equals each value at ticks 3, 7, 11, with `output_ready`=1.
2. Hold `song_valid`=0 for one prefetch: `note`=0 and `output_ready`=0 at that tick, no `song_ready`; `underrun_cnt`=1 when the macro is defined.
3. `pause` high for 10 cycles at count 1: no ticks while paused; after release the next tick arrives 2 cycles later.
4. `song_last` on the 3rd note with DRAIN_TICKS=4: 4 empty ticks follow, then `done` pulses once and `busy` drops the same cycle.
5. `key`=0x05 and `bottom`=0x07 at a tick: `score` +2. With SCORE_W=2 and `score`=3, another hit keeps `score`=3.
6. `abort` asserted together with `pause` in RUN: IDLE next cycle, `note`=0, `output_ready`=0, no further ticks. Async `rst_n` low mid-DRAIN clears all outputs immediately.
